// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_pkg
//  Brief    : Shared opcodes, instruction field positions and fetch FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BRZ  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction word layout; rs2 and imm6 deliberately overlap in [5:3].
    localparam int c_op_msb   = 15;
    localparam int c_op_lsb   = 12;
    localparam int c_rd_msb   = 11;
    localparam int c_rd_lsb   = 9;
    localparam int c_rs1_msb  = 8;
    localparam int c_rs1_lsb  = 6;
    localparam int c_rs2_msb  = 5;
    localparam int c_rs2_lsb  = 3;
    localparam int c_imm6_msb = 5;
    localparam int c_imm6_lsb = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_next_pc.sv
`default_nettype none
// ============================================================================
//  Module   : next_pc_calc
//  Brief    : Combinational next-PC: pc+1, or pc+1+sext(imm6) when branching.
//  Revision : 1.0  initial release
// ============================================================================
module next_pc_calc #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] i_pc,
    input  logic [5:0]    i_imm6,
    input  logic          i_pc_sel,
    output logic [AW-1:0] o_next_pc
);

    logic [AW-1:0] w_seq_pc;
    logic [AW-1:0] w_offset;

    // Signed cast sign-extends imm6; all sums wrap modulo 2^AW.
    assign w_offset  = AW'($signed(i_imm6));
    assign w_seq_pc  = i_pc + AW'(1);
    assign o_next_pc = i_pc_sel ? (w_seq_pc + w_offset) : w_seq_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : PC register, req/ack instruction fetch and valid/ready issue.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [3:0]    OP_BRZ   = instr_fetch_unit_pkg::OP_BRZ,
    parameter logic [3:0]    OP_HALT  = instr_fetch_unit_pkg::OP_HALT
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [3:0]    opcode,
    output logic [2:0]    rd,
    output logic [2:0]    rs1,
    output logic [2:0]    rs2,
    output logic [5:0]    imm6,
    input  logic          pc_sel,
    output logic [AW-1:0] pc,
    output logic          halted
);

    import instr_fetch_unit_pkg::*;

    // A branch opcode that collides with HALT could never be taken.
    if (OP_BRZ == OP_HALT) begin : g_opcode_check
        $error("instr_fetch_unit: OP_BRZ must differ from OP_HALT");
    end

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_pc_target;
    logic [15:0]   r_ir;
    logic          w_ir_load;

    assign opcode    = r_ir[c_op_msb:c_op_lsb];
    assign rd        = r_ir[c_rd_msb:c_rd_lsb];
    assign rs1       = r_ir[c_rs1_msb:c_rs1_lsb];
    assign rs2       = r_ir[c_rs2_msb:c_rs2_lsb];
    assign imm6      = r_ir[c_imm6_msb:c_imm6_lsb];
    assign pc        = r_pc;
    assign imem_addr = r_pc;

    next_pc_calc #(
        .AW (AW)
    ) u_next_pc_calc (
        .i_pc      (r_pc),
        .i_imm6    (imm6),
        .i_pc_sel  (pc_sel),
        .o_next_pc (w_pc_target)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        imem_req     = 1'b0;
        issue_valid  = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_load    = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) begin
                    // HALT keeps pc pointing at itself for debug visibility.
                    if (opcode == OP_HALT) begin
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next    = w_pc_target;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_ir_load) begin
                r_ir <= imem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Brief    : Self-checking bench for instr_fetch_unit (table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] word;
        int          ack_dly;
        int          rdy_dly;
        logic        sel;
        logic [7:0]  exp_next;
        logic        is_halt;
    } vec_t;

    typedef struct {
        logic [26:0] fields;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2;
    logic [5:0]  imm6;
    logic        pc_sel = 1'b0;
    logic [7:0]  pc;
    logic        halted;

    logic        req_ff, valid_ff, halted_ff;
    logic [7:0]  addr_ff, pc_ff;
    logic [3:0]  opcode_ff;
    logic [2:0]  rd_ff, rs1_ff, rs2_ff;
    logic [5:0]  imm6_ff;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    exp_t        sb[$];
    vec_t        vecs[14];

    instr_fetch_unit #(.AW(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm6(imm6), .pc_sel(pc_sel), .pc(pc), .halted(halted)
    );

    // Same stimulus, reset PC at the top of the address space.
    instr_fetch_unit #(.AW(8), .RESET_PC(8'hFF)) u_dut_ff (
        .clk(clk), .rst(rst), .imem_req(req_ff), .imem_addr(addr_ff),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .issue_valid(valid_ff),
        .issue_ready(issue_ready), .opcode(opcode_ff), .rd(rd_ff), .rs1(rs1_ff),
        .rs2(rs2_ff), .imm6(imm6_ff), .pc_sel(pc_sel), .pc(pc_ff), .halted(halted_ff)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [26:0] pack(input logic [15:0] w, input logic [7:0] p);
        return {w[15:12], w[11:9], w[8:6], w[5:3], w[5:0], p};
    endfunction

    function automatic logic [26:0] act_fields();
        return {opcode, rd, rs1, rs2, imm6, pc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        issue_ready = 1'b0;
        pc_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 8'h00;
        m_ir = 16'h0000;
        sb.delete();
    endtask

    task automatic run_instr(input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        issue_ready = (v.rdy_dly == 0);
        pc_sel = ~v.sel;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        check("fetch_addr_ff", {24'd0, addr_ff}, {24'd0, m_pc + 8'hFF});
        for (int i = 0; i < v.ack_dly; i++) begin
            @(negedge clk);
            check("fetch_hold_req", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, m_pc});
            check("fetch_hold_ir", {5'd0, act_fields()}, {5'd0, pack(m_ir, m_pc)});
        end
        imem_ack = 1'b1;
        imem_rdata = v.word;
        e.fields = pack(v.word, m_pc);
        sb.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 16'hBEEF;
        m_ir = v.word;
        check("issue_latency", {30'd0, issue_valid, imem_req}, 32'd2);
        for (int i = 0; i < v.rdy_dly; i++) begin
            check("stall_state", {30'd0, issue_valid, imem_req}, 32'd2);
            check("stall_fields", {5'd0, act_fields()}, {5'd0, sb[0].fields});
            imem_ack = 1'b1;
            imem_rdata = 16'hDEAD ^ 16'(i);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        issue_ready = 1'b1;
        pc_sel = v.sel;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("issue_fields", {5'd0, act_fields()}, {5'd0, e.fields});
        end
        @(negedge clk);
        issue_ready = 1'b0;
        pc_sel = 1'b0;
        if (v.is_halt) begin
            check("halt_state", {29'd0, halted, imem_req, issue_valid}, 32'd4);
            check("halt_pc", {24'd0, pc}, {24'd0, m_pc});
        end else begin
            check("next_req", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, v.exp_next});
            m_pc = v.exp_next;
        end
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 0, 0, 1'b0, 8'h01, 1'b0};
        vecs[1]  = '{16'h2000, 3, 0, 1'b0, 8'h02, 1'b0};
        vecs[2]  = '{16'h3ABC, 0, 5, 1'b0, 8'h03, 1'b0};
        vecs[3]  = '{16'hC00C, 1, 1, 1'b1, 8'h10, 1'b0};
        vecs[4]  = '{16'hC03E, 0, 0, 1'b1, 8'h0F, 1'b0};
        vecs[5]  = '{16'hC03E, 0, 2, 1'b0, 8'h10, 1'b0};
        vecs[6]  = '{16'hC020, 0, 0, 1'b1, 8'hF1, 1'b0};
        vecs[7]  = '{16'hC00C, 2, 0, 1'b1, 8'hFE, 1'b0};
        vecs[8]  = '{16'hC001, 0, 1, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{16'hC03E, 0, 0, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{16'h5555, 2, 2, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{16'h7FFF, 0, 0, 1'b1, 8'h00, 1'b0};
        vecs[12] = '{16'hC01F, 1, 0, 1'b1, 8'h20, 1'b0};
        vecs[13] = '{16'hF000, 0, 3, 1'b1, 8'h00, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_ctrl", {29'd0, imem_req, issue_valid, halted}, 32'd0);
        check("reset_fields", {5'd0, act_fields()}, {5'd0, pack(16'h0000, 8'h00)});
        check("reset_pc_ff", {24'd0, pc_ff}, 32'h0000_00FF);
        rst = 1'b0;
        m_pc = 8'h00;
        m_ir = 16'h0000;
        @(negedge clk);
        check("req_cycle1", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});

        for (int k = 0; k < 14; k++) begin
            run_instr(vecs[k]);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_hold", {28'd0, halted, halted_ff, imem_req, issue_valid}, 32'hC);
        end

        // Reset while an instruction is waiting in ISSUE.
        do_reset();
        check("rst_req_low", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 16'h1111;
        @(negedge clk);
        imem_ack = 1'b0;
        check("pre_rst_valid", {31'd0, issue_valid}, 32'd1);
        rst = 1'b1;
        issue_ready = 1'b1;
        pc_sel = 1'b1;
        @(negedge clk);
        check("rst_issue_ctrl", {29'd0, imem_req, issue_valid, halted}, 32'd0);
        check("rst_issue_fields", {5'd0, act_fields()}, {5'd0, pack(16'h0000, 8'h00)});
        rst = 1'b0;
        issue_ready = 1'b0;
        pc_sel = 1'b0;
        @(negedge clk);
        check("rst_issue_refetch", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});

        // Reset during FETCH with an ack in the same cycle: the ack is dropped.
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 16'h2222;
        @(negedge clk);
        check("rst_fetch_ctrl", {29'd0, imem_req, issue_valid, halted}, 32'd0);
        check("rst_fetch_fields", {5'd0, act_fields()}, {5'd0, pack(16'h0000, 8'h00)});
        rst = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        check("rst_fetch_refetch", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h00});
        m_pc = 8'h00;
        m_ir = 16'h0000;
        run_instr(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
